// File: rtl/multdiv_stall_ctrl.sv
// Sequencer for the multi-cycle multiplier/divider in the execute stage.
// Starts the unit on a mul/div issue, stalls the pipeline until the result
// (or a watchdog timeout) arrives, then emits a one-cycle writeback packet.
module multdiv_stall_ctrl #(
  parameter int unsigned MAX_CYCLES   = 40,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [4:0]  dx_rd,
  output logic        md_start_mult,
  output logic        md_start_div,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        stall_pipe,
  output logic        busy,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_div_q;
  logic [4:0]         rd_q;
  logic               after_rst_q;
  logic               accept;
  logic               timeout;
  logic               finish;
  logic               exc;

  // Accept/start/stall decode; issue is blocked during reset and the cycle after
  always_comb begin
    accept        = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    timeout       = (cnt_q == CNT_W'(MAX_CYCLES - 1));
    finish        = 1'b0;
    exc           = 1'b0;
    state_d       = state_q;
    if (state_q == IDLE && !reset && !after_rst_q && (ctrl_MULT || ctrl_DIV)) begin
      accept = 1'b1;
    end
    md_start_mult = accept && ctrl_MULT;
    md_start_div  = accept && !ctrl_MULT && ctrl_DIV;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (md_resultRDY || timeout) begin
          finish  = 1'b1;
          exc     = md_resultRDY ? md_exception : 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_pipe = accept || (state_q == RUN);
  assign busy       = (state_q != IDLE);

  // State, counter, latched op and registered writeback packet
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_div_q    <= 1'b0;
      rd_q        <= '0;
      after_rst_q <= 1'b1;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      state_q     <= state_d;
      after_rst_q <= 1'b0;
      wb_valid    <= finish;
      wb_we       <= 1'b0;
      if (accept) begin
        op_div_q <= !ctrl_MULT;
        rd_q     <= dx_rd;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        if (exc) begin
          wb_rd   <= 5'(RSTATUS_REG);
          wb_data <= op_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          wb_we   <= 1'b1;
        end else begin
          wb_rd   <= rd_q;
          wb_data <= md_result;
          wb_we   <= (rd_q != 5'd0);
        end
      end
    end
  end

endmodule
